// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load size codes, FSM encoding,
// and the load alignment legality check.
package wb_pkg;

  localparam logic [1:0] LOAD_BYTE = 2'b00;
  localparam logic [1:0] LOAD_HALF = 2'b01;
  localparam logic [1:0] LOAD_WORD = 2'b10;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  // A load is illegal if its address is not a multiple of its size.
  // The reserved size code is always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      LOAD_BYTE: bad = 1'b0;
      LOAD_HALF: bad = addr_lo[0];
      LOAD_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Lane selection and sign/zero extension of a little-endian memory read word.
module load_align
  import wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        load_signed,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
  assign half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Pick the lane for the load size and extend it to a full word.
  always_comb begin
    data = rdata;
    case (size)
      LOAD_BYTE: data = {{24{load_signed & byte_lane[7]}}, byte_lane};
      LOAD_HALF: data = {{16{load_signed & half_lane[15]}}, half_lane};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts retiring instructions from MEM, waits for load data
// with a timeout, and issues one registered register-file write per instruction.
//
// Handshake: an instruction is consumed on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE and out of reset; there is no skid buffer, so a
// held in_valid while in_ready is low is simply presented again later.
module wb_stage
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_regwrite,
  input  logic        in_memtoreg,
  input  logic [4:0]  in_wrreg,
  input  logic [31:0] in_alu_result,
  input  logic [1:0]  in_load_size,
  input  logic        in_load_signed,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        regwrite,
  output logic [4:0]  wrreg,
  output logic [31:0] wrdata,
  output logic        load_err,
  output wb_state_e   state_dbg
);

  localparam logic [TIMEOUT_W-1:0] LAST_CNT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  wb_state_e            state;
  logic [TIMEOUT_W-1:0] wait_cnt;

  // Context of the load currently waiting for its data.
  logic [4:0]  ctx_wrreg;
  logic [1:0]  ctx_size;
  logic        ctx_signed;
  logic [1:0]  ctx_addr_lo;

  logic [31:0] aligned_data;
  logic        accept;

  assign in_ready  = (state == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign state_dbg = state;

  load_align u_load_align (
    .rdata       (mem_rdata),
    .size        (ctx_size),
    .load_signed (ctx_signed),
    .addr_lo     (ctx_addr_lo),
    .data        (aligned_data)
  );

  // FSM, timeout counter, load context and registered write-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      ctx_wrreg   <= '0;
      ctx_size    <= '0;
      ctx_signed  <= 1'b0;
      ctx_addr_lo <= '0;
      regwrite    <= 1'b0;
      wrreg       <= '0;
      wrdata      <= '0;
      load_err    <= 1'b0;
    end else begin
      regwrite <= 1'b0;
      load_err <= 1'b0;
      case (state)
        IDLE: begin
          // Read data with no load outstanding is dropped and flagged.
          if (mem_rvalid) load_err <= 1'b1;
          if (accept) begin
            if (in_memtoreg && in_regwrite) begin
              if (is_misaligned(in_load_size, in_alu_result[1:0])) begin
                load_err <= 1'b1;
              end else begin
                ctx_wrreg   <= in_wrreg;
                ctx_size    <= in_load_size;
                ctx_signed  <= in_load_signed;
                ctx_addr_lo <= in_alu_result[1:0];
                wait_cnt    <= '0;
                state       <= WAIT_LOAD;
              end
            end else if (in_regwrite && (in_wrreg != 5'd0)) begin
              regwrite <= 1'b1;
              wrreg    <= in_wrreg;
              wrdata   <= in_alu_result;
            end
          end
        end
        WAIT_LOAD: begin
          wait_cnt <= wait_cnt + 1'b1;
          // Data arriving on the last allowed cycle still completes the load.
          if (mem_rvalid) begin
            state <= IDLE;
            if (ctx_wrreg != 5'd0) begin
              regwrite <= 1'b1;
              wrreg    <= ctx_wrreg;
              wrdata   <= aligned_data;
            end
          end else if (wait_cnt == LAST_CNT) begin
            load_err <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios per feature, with every expected
// register write queued at stimulus time and compared when the DUT writes.
module tb_wb_stage;
  import wb_pkg::*;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic [4:0]  in_wrreg;
  logic [31:0] in_alu_result;
  logic [1:0]  in_load_size;
  logic        in_load_signed;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        regwrite;
  logic [4:0]  wrreg;
  logic [31:0] wrdata;
  logic        load_err;
  wb_state_e   state_dbg;

  logic [36:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int exp_err = 0;

  wb_stage #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_regwrite    (in_regwrite),
    .in_memtoreg    (in_memtoreg),
    .in_wrreg       (in_wrreg),
    .in_alu_result  (in_alu_result),
    .in_load_size   (in_load_size),
    .in_load_signed (in_load_signed),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .regwrite       (regwrite),
    .wrreg          (wrreg),
    .wrdata         (wrdata),
    .load_err       (load_err),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (load_err) err_seen++;
      if (regwrite) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got wrreg=%0d wrdata=%08h, want no write", wrreg, wrdata);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          if ({wrreg, wrdata} !== e) begin
            errors++;
            $display("FAIL write_data: got wrreg=%0d wrdata=%08h, want wrreg=%0d wrdata=%08h",
                     wrreg, wrdata, e[36:32], e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_align(input logic [31:0] rd, input logic [1:0] a,
                                              input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    if (sz == LOAD_BYTE) begin
      v = (rd >> (a * 8)) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == LOAD_HALF) begin
      v = (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid = 0; in_regwrite = 0; in_memtoreg = 0; in_wrreg = 0;
    in_alu_result = 0; in_load_size = 0; in_load_signed = 0;
    mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic issue(input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [1:0] sz, input logic sg);
    in_valid = 1; in_regwrite = rw; in_memtoreg = m2r; in_wrreg = rd;
    in_alu_result = alu; in_load_size = sz; in_load_signed = sg;
  endtask

  // Issue a load, return rvalid `dly` cycles after accept, check the write.
  task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [1:0] sz,
                         input logic sg, input int dly, input logic [31:0] rdat,
                         input logic [31:0] exp_data);
    issue(1, 1, rd, addr, sz, sg);
    @(negedge clk);
    in_valid = 0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL load_wait_ready: got %b want 0", in_ready);
    end
    repeat (dly - 1) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || regwrite !== 1'b0) begin
      errors++; $display("FAIL load_still_waiting: got ready=%b regwrite=%b want 0 0", in_ready, regwrite);
    end
    mem_rvalid = 1; mem_rdata = rdat;
    if (rd != 0) exp_q.push_back({rd, exp_data});
    @(negedge clk);
    mem_rvalid = 0;
    checks++;
    if (regwrite !== (rd != 0) || in_ready !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_done: got regwrite=%b ready=%b err=%b want %b 1 0",
               regwrite, in_ready, load_err, (rd != 0));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1; idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({regwrite, wrreg, wrdata, load_err, in_ready} !== 40'd0 || state_dbg !== IDLE) begin
      errors++; $display("FAIL reset_outputs: got rw=%b rd=%0d d=%08h err=%b rdy=%b, want all 0",
                         regwrite, wrreg, wrdata, load_err, in_ready);
    end
    reset = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_alu();
    for (int i = 0; i < 6; i++) begin
      logic [4:0]  rd;
      logic [31:0] v;
      rd = (i == 0) ? 5'd8 : 5'($urandom_range(1, 31));
      v  = (i == 0) ? 32'h0000_1234 : $urandom;
      issue(1, 0, rd, v, 2'b00, 0);
      exp_q.push_back({rd, v});
      @(negedge clk);
      checks++;
      if (regwrite !== 1'b1 || in_ready !== 1'b1) begin
        errors++; $display("FAIL alu_write: got regwrite=%b ready=%b want 1 1", regwrite, in_ready);
      end
    end
    // A load with regwrite clear behaves like a non-writing ALU op.
    issue(0, 1, 5'd7, 32'h0000_0001, LOAD_WORD, 0);
    @(negedge clk);
    in_valid = 0;
    checks++;
    if (regwrite !== 1'b0 || in_ready !== 1'b1 || load_err !== 1'b0) begin
      errors++; $display("FAIL load_no_regwrite: got rw=%b rdy=%b err=%b want 0 1 0",
                         regwrite, in_ready, load_err);
    end
  endtask

  task automatic test_loads();
    do_load(5'd5, 32'h0000_1003, LOAD_BYTE, 1, 3, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load(5'd6, 32'h0000_2002, LOAD_HALF, 0, 2, 32'hBEEF_1234, 32'h0000_BEEF);
    do_load(5'd7, 32'h0000_2000, LOAD_HALF, 1, 1, 32'hBEEF_9234, 32'hFFFF_9234);
    do_load(5'd9, 32'h0000_3000, LOAD_WORD, 0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    // rvalid on the last allowed cycle wins over the timeout.
    do_load(5'd10, 32'h0000_3001, LOAD_BYTE, 0, TO, 32'h0000_A500, 32'h0000_00A5);
    for (int i = 0; i < 6; i++) begin
      logic [1:0]  sz;
      logic [1:0]  a;
      logic        sg;
      logic [31:0] rdat;
      sz   = 2'($urandom_range(0, 2));
      a    = (sz == LOAD_BYTE) ? 2'($urandom_range(0, 3)) : (sz == LOAD_HALF) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      sg   = 1'($urandom_range(0, 1));
      rdat = $urandom;
      do_load(5'($urandom_range(1, 31)), {30'($urandom), a}, sz, sg, $urandom_range(1, TO),
              rdat, model_align(rdat, a, sz, sg));
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sizes[3] = '{LOAD_HALF, LOAD_WORD, 2'b11};
    logic [31:0] addrs[3] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0000};
    for (int i = 0; i < 3; i++) begin
      issue(1, 1, 5'd6, addrs[i], sizes[i], 0);
      exp_err++;
      @(negedge clk);
      in_valid = 0;
      checks++;
      if (load_err !== 1'b1 || regwrite !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL misaligned_%0d: got err=%b rw=%b rdy=%b want 1 0 1",
                           i, load_err, regwrite, in_ready);
      end
    end
  endtask

  task automatic test_timeout();
    issue(1, 1, 5'd12, 32'h0000_0000, LOAD_WORD, 0);
    @(negedge clk);
    in_valid = 0;
    repeat (TO - 1) @(negedge clk);
    checks++;
    if (load_err !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL timeout_early: got err=%b rdy=%b want 0 0", load_err, in_ready);
    end
    exp_err++;
    @(negedge clk);
    checks++;
    if (load_err !== 1'b1 || regwrite !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_pulse: got err=%b rw=%b rdy=%b want 1 0 1",
                         load_err, regwrite, in_ready);
    end
    @(negedge clk);
    checks++;
    if (load_err !== 1'b0) begin
      errors++; $display("FAIL timeout_single_pulse: got %b want 0", load_err);
    end
  endtask

  task automatic test_zero_reg();
    issue(1, 0, 5'd0, 32'hCAFE_F00D, 2'b00, 0);
    @(negedge clk);
    in_valid = 0;
    checks++;
    if (regwrite !== 1'b0) begin
      errors++; $display("FAIL alu_zero_reg: got regwrite=%b want 0", regwrite);
    end
    do_load(5'd0, 32'h0000_0000, LOAD_WORD, 0, 2, 32'h1111_2222, 32'h0);
    // Spurious read data while idle.
    mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
    exp_err++;
    @(negedge clk);
    mem_rvalid = 0;
    checks++;
    if (load_err !== 1'b1 || regwrite !== 1'b0) begin
      errors++; $display("FAIL spurious_rvalid: got err=%b rw=%b want 1 0", load_err, regwrite);
    end
  endtask

  task automatic test_reset_mid_load();
    issue(1, 0, 5'd3, 32'h0BAD_0BAD, 2'b00, 0);
    exp_q.push_back({5'd3, 32'h0BAD_0BAD});
    @(negedge clk);
    issue(1, 1, 5'd4, 32'h0000_0000, LOAD_WORD, 0);
    @(negedge clk);
    in_valid = 0;
    checks++;
    if (state_dbg !== WAIT_LOAD) begin
      errors++; $display("FAIL mid_load_state: got %0d want %0d", state_dbg, WAIT_LOAD);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({regwrite, wrreg, wrdata, load_err, in_ready} !== 40'd0 || state_dbg !== IDLE) begin
      errors++; $display("FAIL reset_mid_load: got rw=%b rd=%0d d=%08h err=%b rdy=%b, want all 0",
                         regwrite, wrreg, wrdata, load_err, in_ready);
    end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'h7777_7777;
    exp_err++;
    @(negedge clk);
    mem_rvalid = 0;
    checks++;
    if (load_err !== 1'b1 || regwrite !== 1'b0) begin
      errors++; $display("FAIL rvalid_after_reset: got err=%b rw=%b want 1 0", load_err, regwrite);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_misaligned();
    test_timeout();
    test_zero_reg();
    test_reset_mid_load();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL writes_outstanding: got %0d pending want 0", exp_q.size());
    end
    checks++;
    if (err_seen != exp_err) begin
      errors++; $display("FAIL load_err_count: got %0d want %0d", err_seen, exp_err);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
